myadder1_example_number_checker: RTL
====================================

// Module: myadder1_example_number_checker
// PURPOSE
//   AXI4-Stream sink that consumes the incrementing-number stream produced by the
//   kernel's number generator and checks it beat by beat: data pattern, tkeep and
//   tlast position. Sits on the kernel's stream-input side (loopback/self-test path).
//   Reports per-run pass/fail, error count and first failing beat; pulses ap_done.
// PARAMETERS
//   C_S_AXIS_TDATA_WIDTH  128    stream width, bits; multiple of C_NUMBER_BIT_WIDTH
//   C_NUMBER_BIT_WIDTH    32     width of one number lane (clipped to TDATA width)
//   C_LENGTH_IN_BYTES     16384  expected transfer length per run, bytes
//   C_THROTTLE_EN         0      1: deassert tready 1 cycle in every 4 while running
// PORTS
//   aclk              in   1        clock; all logic on rising edge
//   areset_n          in   1        asynchronous, active-low reset
//   ap_start          in   1        level; rising edge arms one check run
//   ap_done           out  1        1-cycle pulse when run completes
//   s_axis_tvalid     in   1        stream valid
//   s_axis_tready     out  1        stream ready
//   s_axis_tdata      in   TDATA    stream data
//   s_axis_tkeep      in   TDATA/8  byte qualifiers
//   s_axis_tlast      in   1        end of transfer
//   pass              out  1        valid with ap_done; 1 = zero errors this run
//   error_count       out  32       errored beats this run (saturates at 2^32-1)
//   first_error_beat  out  32       beat index of first error; 0xFFFF_FFFF if none
// BEHAVIOUR
//   Derived: NB=min(NUMBER,TDATA); LANES=TDATA/NB; SB=LANES>1?clog2(LANES):0;
//   BEATS=ceil(LEN/(TDATA/8)); REM=LEN%(TDATA/8).
//   Reset (areset_n=0, async, any state): state=IDLE, s_axis_tready=0, ap_done=0,
//   pass=0, error_count=0, first_error_beat=0xFFFF_FFFF, beat counter=0,
//   throttle counter=0, ap_start edge register=0.
//   FSM: IDLE -> RUN on go (ap_start & ~ap_start_q); counters/error regs cleared same
//   edge. RUN -> DONE on handshake of beat BEATS-1 or on any beat carrying tlast.
//   DONE -> IDLE next cycle (ap_done=1 exactly in DONE; pass/error regs hold until next go).
//   go while RUN or DONE ignored; ap_start held high does not re-arm.
//   tready: 1 in RUN only; if C_THROTTLE_EN, 2-bit counter free-runs in RUN, tready=0
//   when counter==3. tready never depends on tvalid. tready=0 in IDLE/DONE.
//   Handshake = tvalid & tready; only handshaken beats are checked/counted.
//   Expected beat b: lane k (bits k*NB+:NB) = {b[NB-SB-1:0], k[SB-1:0]} (counter wraps
//   mod 2^(NB-SB)); tkeep = all ones, except beat BEATS-1 when REM>0: (1<<REM)-1;
//   tlast = 1 iff b==BEATS-1.
//   Data compared only on bytes with expected tkeep=1. A beat is errored if any of:
//   data mismatch, tkeep != expected, tlast != expected. Max one count per beat.
//   Early tlast (b<BEATS-1): beat counted as errored, run ends. Missing tlast on beat
//   BEATS-1: errored, run still ends there.
//   first_error_beat captures b on first errored beat only. pass=(error_count==0).
//   Latency: check registered; ap_done asserts 2 cycles after final handshake
//   (compare stage + DONE), error regs final when ap_done=1.
//   Beat counter 32 bits; no overflow within a run (BEATS < 2^32).
//   Reset mid-run: run abandoned, no ap_done; stream may be left mid-packet.
// TESTING
//   1 defaults, ideal source 1024 beats, tlast on 1023 -> ap_done once, pass=1,
//     error_count=0, first_error_beat=0xFFFF_FFFF.
//   2 beat 5 lane 2 word corrupted (0x16 -> 0x17) -> pass=0, error_count=1,
//     first_error_beat=5, run still ends at beat 1023.
//   3 LEN=100, TDATA=128: 7 beats, last tkeep=0x000F; send 0xFFFF instead -> error_count=1,
//     first_error_beat=6; garbage in masked bytes with correct tkeep -> pass=1.
//   4 tlast asserted on beat 10 -> ap_done after beat 10, error_count=1,
//     first_error_beat=10; further beats not accepted (tready=0).
//   5 C_THROTTLE_EN=1 with random tvalid gaps -> tready low every 4th RUN cycle,
//     pass=1; go pulse during RUN ignored (single ap_done).
//   6 areset_n low at beat 300 -> outputs to reset values asynchronously, no ap_done;
//     new go after release runs clean from beat 0 -> pass=1.

Source files
------------

// File: rtl/myadder1_example_number_checker.sv
// AXI4-Stream sink that checks an incrementing-number stream beat by beat
// (data lanes, tkeep, tlast position) and reports pass, error count and first bad beat.
module myadder1_example_number_checker #(
    parameter int C_S_AXIS_TDATA_WIDTH = 128,
    parameter int C_NUMBER_BIT_WIDTH   = 32,
    parameter int C_LENGTH_IN_BYTES    = 16384,
    parameter int C_THROTTLE_EN        = 0
) (
    input  logic                                aclk,
    input  logic                                areset_n,
    input  logic                                ap_start,
    output logic                                ap_done,
    input  logic                                s_axis_tvalid,
    output logic                                s_axis_tready,
    input  logic [C_S_AXIS_TDATA_WIDTH-1:0]     s_axis_tdata,
    input  logic [C_S_AXIS_TDATA_WIDTH/8-1:0]   s_axis_tkeep,
    input  logic                                s_axis_tlast,
    output logic                                pass,
    output logic [31:0]                         error_count,
    output logic [31:0]                         first_error_beat
);

    localparam int NB    = (C_NUMBER_BIT_WIDTH < C_S_AXIS_TDATA_WIDTH) ?
                           C_NUMBER_BIT_WIDTH : C_S_AXIS_TDATA_WIDTH;
    localparam int LANES = C_S_AXIS_TDATA_WIDTH / NB;
    localparam int SB    = (LANES > 1) ? $clog2(LANES) : 0;
    localparam int KW    = C_S_AXIS_TDATA_WIDTH / 8;
    localparam int BEATS = (C_LENGTH_IN_BYTES + KW - 1) / KW;
    localparam int REM   = C_LENGTH_IN_BYTES % KW;
    localparam logic [31:0] LAST_BEAT = 32'(BEATS - 1);

    // FLUSH is the compare-stage cycle for the final beat; tready is already low there.
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_FLUSH = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]  state_q, state_d;
    logic        ap_start_q;
    logic [31:0] beat_cnt_q, beat_cnt_d;
    logic [1:0]  thr_cnt_q, thr_cnt_d;
    logic [31:0] err_cnt_q, err_cnt_d;
    logic [31:0] feb_q, feb_d;
    logic        pass_q, pass_d;

    logic                              stg_valid_q;
    logic [31:0]                       stg_beat_q;
    logic [C_S_AXIS_TDATA_WIDTH-1:0]   stg_data_q;
    logic [KW-1:0]                     stg_keep_q;
    logic                              stg_last_q;

    logic                              go;
    logic                              hs;
    logic                              final_beat;
    logic [C_S_AXIS_TDATA_WIDTH-1:0]   exp_data;
    logic [KW-1:0]                     exp_keep;
    logic                              exp_last;
    logic                              data_err;
    logic                              beat_err;

    assign go            = ap_start & ~ap_start_q & (state_q == S_IDLE);
    assign s_axis_tready = (state_q == S_RUN) &&
                           !((C_THROTTLE_EN != 0) && (thr_cnt_q == 2'd3));
    assign hs            = s_axis_tvalid & s_axis_tready;
    assign final_beat    = hs & (s_axis_tlast | (beat_cnt_q == LAST_BEAT));

    assign ap_done          = (state_q == S_DONE);
    assign pass             = pass_q;
    assign error_count      = err_cnt_q;
    assign first_error_beat = feb_q;

    // Expected pattern for the beat sitting in the compare stage.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        exp_data = '0;
        exp_keep = '1;
        for (int k = 0; k < LANES; k++) begin
            exp_data[k*NB +: NB] = NB'((NB'(stg_beat_q) << SB) | NB'(k));
        end
        if ((REM != 0) && (stg_beat_q == LAST_BEAT)) begin
            for (int i = 0; i < KW; i++) begin
                exp_keep[i] = (i < REM);
            end
        end
        exp_last = (stg_beat_q == LAST_BEAT);
        data_err = 1'b0;
        for (int i = 0; i < KW; i++) begin
            if (exp_keep[i] && (stg_data_q[i*8 +: 8] != exp_data[i*8 +: 8])) begin
                data_err = 1'b1;
            end
        end
        beat_err = data_err | (stg_keep_q != exp_keep) | (stg_last_q != exp_last);
    end

    always_comb begin
        state_d    = state_q;
        beat_cnt_d = beat_cnt_q;
        thr_cnt_d  = thr_cnt_q;
        err_cnt_d  = err_cnt_q;
        feb_d      = feb_q;
        pass_d     = pass_q;

        case (state_q)
            S_IDLE:  if (go) state_d = S_RUN;
            S_RUN:   if (final_beat) state_d = S_FLUSH;
            S_FLUSH: state_d = S_DONE;
            default: state_d = S_IDLE;
        endcase

        if (go) begin
            beat_cnt_d = '0;
            thr_cnt_d  = '0;
            err_cnt_d  = '0;
            feb_d      = '1;
            pass_d     = 1'b0;
        end else begin
            if (hs) beat_cnt_d = beat_cnt_q + 32'd1;
            if (state_q == S_RUN) thr_cnt_d = thr_cnt_q + 2'd1;
            if (stg_valid_q && beat_err) begin
                if (err_cnt_q != 32'hFFFF_FFFF) err_cnt_d = err_cnt_q + 32'd1;
                if (err_cnt_q == 32'd0) feb_d = stg_beat_q;
            end
            // Final beat is compared during FLUSH, so the verdict folds it in here.
            if (state_q == S_FLUSH) pass_d = (err_cnt_d == 32'd0);
        end
    end

    always_ff @(posedge aclk or negedge areset_n) begin
        if (!areset_n) begin
            state_q     <= S_IDLE;
            ap_start_q  <= 1'b0;
            beat_cnt_q  <= '0;
            thr_cnt_q   <= '0;
            err_cnt_q   <= '0;
            feb_q       <= '1;
            pass_q      <= 1'b0;
            stg_valid_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            state_q     <= state_d;
            ap_start_q  <= ap_start;
            beat_cnt_q  <= beat_cnt_d;
            thr_cnt_q   <= thr_cnt_d;
            err_cnt_q   <= err_cnt_d;
            feb_q       <= feb_d;
            pass_q      <= pass_d;
            stg_valid_q <= hs;
        end
    end

    // NOTE: the compare-stage payload has no reset; stg_valid_q alone qualifies it.
    always_ff @(posedge aclk) begin
        if (hs) begin
            stg_beat_q <= beat_cnt_q;
            stg_data_q <= s_axis_tdata;
            stg_keep_q <= s_axis_tkeep;
            stg_last_q <= s_axis_tlast;
        end
    end

endmodule
